spi_master_arbiter: RTL and testbench

- Shares one spi_master instance between NREQ requesters (ADC/PLL/attenuator config engines).
- Round-robin arbitration, one transaction at a time.
- Drives the master's trigger/cs_in/cs_in_idle/din and consumes dout/dvld with an ack handshake.
- Returns readback data and a done pulse to the granted requester.

---
 rtl/spi_master_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one spi_master between NREQ requesters.
// Optional watchdog on the WAIT state: define SPI_MASTER_ARBITER_TIMEOUT_EN.
module spi_master_arbiter #(
  parameter int unsigned     NREQ    = 4,
  parameter int unsigned     NCS     = 3,
  parameter int unsigned     DW      = 24,
  parameter logic [NCS-1:0]  CS_IDLE = 3'b111,
  parameter int unsigned     TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*NCS-1:0] req_cs,
  input  logic [NREQ*DW-1:0]  req_din,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [DW-1:0]       rdata,
  output logic                err,
  output logic                m_trigger,
  output logic [NCS-1:0]      m_cs,
  output logic [NCS-1:0]      m_cs_idle,
  output logic [DW-1:0]       m_din,
  output logic                m_ack,
  input  logic [DW-1:0]       m_dout,
  input  logic                m_dvld
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 8192) begin : g_param_check
    $error("spi_master_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              trig_q, trig_d;
  logic [NCS-1:0]    cs_q, cs_d;
  logic [DW-1:0]     din_q, din_d;
  logic              ack_q, ack_d;

`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
  localparam logic [12:0] TimeoutLast = 13'(TIMEOUT - 1);
  logic [12:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  // Unpacked views of the flat per-requester buses.
  logic [NCS-1:0] cs_arr  [NREQ];
  logic [DW-1:0]  din_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign cs_arr[i]  = req_cs[i*NCS +: NCS];
    assign din_arr[i] = req_din[i*DW +: DW];
  end

  // First requester at or after rr+1, wrapping modulo NREQ.
  logic          sel_found;
  logic [IW-1:0] sel_idx;

  always_comb begin
    int unsigned   j;
    logic [IW-1:0] jj;
    sel_found = 1'b0;
    sel_idx   = rr_q;
    j         = 0;
    jj        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j  = (32'(rr_q) + k) % NREQ;
      jj = IW'(j);
      if (!sel_found && req[jj]) begin
        sel_found = 1'b1;
        sel_idx   = jj;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rdata_d = rdata_q;
    trig_d  = 1'b0;
    cs_d    = cs_q;
    din_d   = din_q;
    ack_d   = ack_q;
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (sel_found) begin
          idx_d          = sel_idx;
          rr_d           = sel_idx;
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          cs_d           = cs_arr[sel_idx];
          din_d          = din_arr[sel_idx];
          trig_d         = 1'b1;
          state_d        = StIssue;
        end
      end
      StIssue: begin
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (m_dvld) begin
          rdata_d        = m_dout;
          done_d[idx_q]  = 1'b1;
          gnt_d          = '0;
          ack_d          = 1'b1;
          state_d        = StAck;
        end
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          // Abandon the transfer without handshaking; the master never answered.
          rdata_d        = '0;
          done_d[idx_q]  = 1'b1;
          err_d          = 1'b1;
          gnt_d          = '0;
          state_d        = StIdle;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
`endif
      end
      StAck: begin
        if (!m_dvld) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rr_q    <= IW'(NREQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      trig_q  <= 1'b0;
      cs_q    <= '0;
      din_q   <= '0;
      ack_q   <= 1'b0;
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      trig_q  <= trig_d;
      cs_q    <= cs_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign m_trigger = trig_q;
  assign m_cs      = cs_q;
  assign m_cs_idle = CS_IDLE;
  assign m_din     = din_q;
  assign m_ack     = ack_q;

`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a loopback (dout = ~din) master model.
module tb_spi_master_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned NCS  = 3;
  localparam int unsigned DW   = 24;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*NCS-1:0] req_cs = '0;
  logic [NREQ*DW-1:0]  req_din = '0;
  logic [NREQ-1:0]     gnt, done;
  logic [DW-1:0]       rdata;
  logic                err, m_trigger, m_ack;
  logic [NCS-1:0]      m_cs, m_cs_idle;
  logic [DW-1:0]       m_din;
  logic [DW-1:0]       m_dout = '0;
  logic                m_dvld = 1'b0;

  int errors = 0;
  int checks = 0;
  bit slave_en = 1'b1;
  logic [DW-1:0] din_v [NREQ];

  spi_master_arbiter #(
    .NREQ(NREQ), .NCS(NCS), .DW(DW), .CS_IDLE(3'b111), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_cs(req_cs), .req_din(req_din),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .m_trigger(m_trigger), .m_cs(m_cs), .m_cs_idle(m_cs_idle), .m_din(m_din),
    .m_ack(m_ack), .m_dout(m_dout), .m_dvld(m_dvld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_din();
    for (int i = 0; i < NREQ; i++) req_din[i*DW +: DW] = din_v[i];
  endtask

  task automatic do_reset();
    req = '0;
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_trig(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (m_trigger === 1'b1) ok = 1'b1;
    end
    if (!ok) check({tag, "_trig_timeout"}, 64'(m_trigger), 64'd1);
  endtask

  task automatic wait_done(input string tag, output logic [NREQ-1:0] d);
    bit ok;
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (done !== '0) begin
        ok = 1'b1;
        d  = done;
      end
    end
    if (!ok) check({tag, "_done_timeout"}, 64'(done != '0), 64'd1);
  endtask

  // Master model: answers each trigger a few cycles later with ~din, holds dvld until ack.
  initial begin
    int            rcnt;
    bit            busy;
    logic [DW-1:0] pend;
    rcnt = 0;
    busy = 1'b0;
    pend = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_dvld = 1'b0;
        busy   = 1'b0;
        rcnt   = 0;
      end else if (slave_en) begin
        if (m_trigger && !busy) begin
          busy = 1'b1;
          rcnt = 3;
          pend = ~m_din;
        end else if (busy && !m_dvld) begin
          if (rcnt == 0) begin
            m_dvld = 1'b1;
            m_dout = pend;
          end else begin
            rcnt--;
          end
        end else if (m_dvld && m_ack) begin
          m_dvld = 1'b0;
          busy   = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [NREQ-1:0] d, eg;
    logic [DW-1:0]   er;
    bit              ok, seen, ack_seen;
    int              k, e;
    int              seq [4];
    seq = '{1, 2, 1, 2};

    din_v[0] = 24'hdeadbe;
    din_v[1] = 24'h123456;
    din_v[2] = 24'h0f0f0f;
    din_v[3] = 24'h555aaa;
    load_din();
    req_cs = {3'b011, 3'b010, 3'b001, 3'b000};

    // Reset values
    do_reset();
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_trig", 64'(m_trigger), 64'd0);
    check("rst_cs", 64'(m_cs), 64'd0);
    check("rst_din", 64'(m_din), 64'd0);
    check("rst_ack", 64'(m_ack), 64'd0);
    check("rst_cs_idle", 64'(m_cs_idle), 64'h7);

    // Single request
    req = 4'b0001;
    @(negedge clk);
    check("t1_trig", 64'(m_trigger), 64'd1);
    check("t1_gnt", 64'(gnt), 64'h1);
    check("t1_din", 64'(m_din), 64'hdeadbe);
    check("t1_cs", 64'(m_cs), 64'd0);
    @(negedge clk);
    check("t1_trig_once", 64'(m_trigger), 64'd0);
    check("t1_gnt_hold", 64'(gnt), 64'h1);
    wait_done("t1", d);
    check("t1_done", 64'(d), 64'h1);
    check("t1_rdata", 64'(rdata), 64'h215241);
    check("t1_gnt_fall", 64'(gnt), 64'd0);
    check("t1_err", 64'(err), 64'd0);
    check("t1_ack", 64'(m_ack), 64'd1);
    req = '0;
    @(negedge clk);
    check("t1_done_once", 64'(done), 64'd0);

    // Round-robin with everyone requesting
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      e  = t % 4;
      eg = NREQ'(1) << e;
      wait_trig($sformatf("rr%0d", t), ok);
      check($sformatf("rr%0d_gnt", t), 64'(gnt), 64'(eg));
      check($sformatf("rr%0d_din", t), 64'(m_din), 64'(din_v[e]));
      check($sformatf("rr%0d_cs", t), 64'(m_cs), 64'(e));
      wait_done($sformatf("rr%0d", t), d);
      er = ~din_v[e];
      check($sformatf("rr%0d_done", t), 64'(d), 64'(eg));
      check($sformatf("rr%0d_rdata", t), 64'(rdata), 64'(er));
      din_v[e] = din_v[e] + 24'h0a0b0c;
      load_din();
    end
    req = '0;
    repeat (5) @(negedge clk);

    // Back-to-back: req[1] held, req[2] re-asserts right after its done
    do_reset();
    req = 4'b0110;
    for (int t = 0; t < 4; t++) begin
      eg = NREQ'(1) << seq[t];
      wait_trig($sformatf("bb%0d", t), ok);
      check($sformatf("bb%0d_gnt", t), 64'(gnt), 64'(eg));
      check($sformatf("bb%0d_ack_low", t), 64'(m_ack), 64'd0);
      wait_done($sformatf("bb%0d", t), d);
      check($sformatf("bb%0d_done", t), 64'(d), 64'(eg));
      if (seq[t] == 2 && t < 3) begin
        req[2] = 1'b0;
        @(negedge clk);
        req[2] = 1'b1;
      end
    end
    req = '0;
    repeat (5) @(negedge clk);

    // Withdrawn requests
    do_reset();
    req = 4'b0001;
    wait_trig("wd", ok);
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    wait_done("wd", d);
    er = ~din_v[0];
    check("wd_done0", 64'(d), 64'h1);
    check("wd_rdata", 64'(rdata), 64'(er));
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done !== '0 || m_trigger !== 1'b0 || gnt !== '0) seen = 1'b1;
    end
    check("wd_no_req3", 64'(seen), 64'd0);

    // Reset in the middle of WAIT
    slave_en = 1'b0;
    req = 4'b0010;
    wait_trig("mr", ok);
    check("mr_gnt", 64'(gnt), 64'h2);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    req  = '0;
    #1;
    check("mr_gnt_rst", 64'(gnt), 64'd0);
    check("mr_done_rst", 64'(done), 64'd0);
    check("mr_rdata_rst", 64'(rdata), 64'd0);
    check("mr_trig_rst", 64'(m_trigger), 64'd0);
    check("mr_cs_rst", 64'(m_cs), 64'd0);
    check("mr_din_rst", 64'(m_din), 64'd0);
    check("mr_ack_rst", 64'(m_ack), 64'd0);
    repeat (3) @(negedge clk);
    slave_en = 1'b1;
    rstn = 1'b1;
    req = 4'b0110;
    wait_trig("mr2", ok);
    check("mr2_gnt", 64'(gnt), 64'h2);
    wait_done("mr2", d);
    er = ~din_v[1];
    check("mr2_done", 64'(d), 64'h2);
    check("mr2_rdata", 64'(rdata), 64'(er));
    req = '0;
    repeat (5) @(negedge clk);

`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
    // Watchdog: master never answers
    slave_en = 1'b0;
    req = 4'b0100;
    wait_trig("to", ok);
    ack_seen = 1'b0;
    k = 0;
    for (int i = 1; i <= 80 && k == 0; i++) begin
      @(negedge clk);
      if (m_ack === 1'b1) ack_seen = 1'b1;
      if (done !== '0) begin
        k = i;
        check("to_done", 64'(done), 64'h4);
        check("to_err", 64'(err), 64'd1);
        check("to_rdata", 64'(rdata), 64'd0);
        check("to_gnt", 64'(gnt), 64'd0);
      end
    end
    check("to_latency", 64'(k), 64'd65);
    check("to_no_ack", 64'(ack_seen), 64'd0);
    req = '0;
    @(negedge clk);
    check("to_err_once", 64'(err), 64'd0);
    slave_en = 1'b1;
    req = 4'b0001;
    wait_trig("to2", ok);
    check("to2_gnt", 64'(gnt), 64'h1);
    wait_done("to2", d);
    er = ~din_v[0];
    check("to2_rdata", 64'(rdata), 64'(er));
    check("to2_err", 64'(err), 64'd0);
    req = '0;
    repeat (5) @(negedge clk);
`else
    ack_seen = 1'b0;
    k = 0;
    check("no_timeout_err", 64'(err), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
